// File: rtl/spike_window_emitter_if.sv
// Ready/valid handshake carrying one spike vector per transfer.
//   in_valid : source has a window vector to hand over
//   in_ready : emitter will take in_vec on this rising edge
//   in_vec   : spike vector, in_vec[k]=1 -> spike at window time k
interface spike_window_emitter_if #(
  parameter int LEN = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [0:LEN-1] in_vec;

  modport master (output in_valid, output in_vec, input  in_ready);
  modport slave  (input  in_valid, input  in_vec, output in_ready);
endinterface

// File: rtl/spike_window_emitter.sv
// Turns a spatially encoded spike vector back into a temporal spike train:
// one vector bit per clock over an LEN-cycle window, with optional GAP idle
// clocks between windows. A new vector can be taken on the last window cycle
// (GAP=0) or the last gap cycle, so back-to-back windows have no bubble.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of the in_valid/in_ready/in_vec handshake
//   spike_out  : vec[t] during window cycle t
//   win_start  : window cycle t=0      win_last : window cycle t=LEN-1
//   t_idx      : window time (0 outside EMIT)
//   busy       : in EMIT or GAP
//   first_t    : lowest set index of the accepted vector
//   first_vld  : accepted vector had at least one spike
module spike_window_emitter #(
  parameter int LEN   = 8,
  parameter int GAP   = 0,
  parameter int CNT_W = $clog2(LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spike_window_emitter_if.slave bus,
  output logic                  spike_out,
  output logic                  win_start,
  output logic                  win_last,
  output logic [CNT_W-1:0]      t_idx,
  output logic                  busy,
  output logic [CNT_W-1:0]      first_t,
  output logic                  first_vld
);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(LEN - 1);
  localparam logic [GW-1:0]    G_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_GAP} state_t;

  state_t           state, state_n;
  logic [0:LEN-1]   vec,   vec_n;
  logic [CNT_W-1:0] t,     t_n;
  logic [GW-1:0]    gcnt,  gcnt_n;
  logic [CNT_W-1:0] ft,    ft_n;
  logic             fv,    fv_n;
  logic             rdy, xfer;
  logic [CNT_W-1:0] enc_t;
  logic             enc_v;

  // Lowest index wins: scan downward so the last hit is the smallest k.
  always_comb begin
    enc_t = '0;
    enc_v = |bus.in_vec;
    for (int k = LEN - 1; k >= 0; k--)
      if (bus.in_vec[k]) enc_t = CNT_W'(k);
  end

  // Ready comes from state/counters only, so no path from in_valid.
  always_comb begin
    rdy = 1'b0;
    case (state)
      S_IDLE:  rdy = 1'b1;
      S_EMIT:  rdy = (GAP == 0) && (t == T_LAST);
      S_GAP:   rdy = (gcnt == G_LAST);
      default: rdy = 1'b0;
    endcase
  end

  assign bus.in_ready = rdy;
  assign xfer         = bus.in_valid & rdy;

  always_comb begin
    state_n = state;
    vec_n   = vec;
    t_n     = t;
    gcnt_n  = gcnt;
    ft_n    = ft;
    fv_n    = fv;
    case (state)
      S_IDLE: ;
      S_EMIT: begin
        if (t == T_LAST) begin
          t_n = '0;
          if (GAP == 0) state_n = S_IDLE;
          else begin
            state_n = S_GAP;
            gcnt_n  = '0;
          end
        end else begin
          t_n = t + 1'b1;
        end
      end
      S_GAP: begin
        if (gcnt == G_LAST) state_n = S_IDLE;
        else                gcnt_n  = gcnt + 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
    // A transfer only happens on ready cycles, all of which end the current
    // phase; it overrides the fall-back to IDLE with a fresh window.
    if (xfer) begin
      state_n = S_EMIT;
      vec_n   = bus.in_vec;
      t_n     = '0;
      gcnt_n  = '0;
      ft_n    = enc_t;
      fv_n    = enc_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      vec   <= '0;
      t     <= '0;
      gcnt  <= '0;
      ft    <= '0;
      fv    <= 1'b0;
    end else begin
      state <= state_n;
      vec   <= vec_n;
      t     <= t_n;
      gcnt  <= gcnt_n;
      ft    <= ft_n;
      fv    <= fv_n;
    end
  end

  assign spike_out = (state == S_EMIT) & vec[t];
  assign win_start = (state == S_EMIT) & (t == '0);
  assign win_last  = (state == S_EMIT) & (t == T_LAST);
  assign t_idx     = (state == S_EMIT) ? t : '0;
  assign busy      = (state != S_IDLE);
  assign first_t   = ft;
  assign first_vld = fv;
endmodule

// File: tb/tb_spike_window_emitter.sv
// Two emitters side by side (GAP=0 and GAP=2) fed from per-instance vector
// queues. The reference is a timeline: a vector accepted in cycle c plays out
// in cycles c+1..c+LEN, is followed by GAP busy cycles, and the block is next
// ready in cycle c+LEN+GAP.
module tb_spike_window_emitter;
  localparam int LEN = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spike_window_emitter_if #(.LEN(LEN)) b0 ();
  spike_window_emitter_if #(.LEN(LEN)) b1 ();

  logic       so[2], ws[2], wl[2], by[2], fv[2], rdy[2];
  logic [2:0] ti[2], ft[2];

  spike_window_emitter #(.LEN(LEN), .GAP(0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave),
    .spike_out(so[0]), .win_start(ws[0]), .win_last(wl[0]), .t_idx(ti[0]),
    .busy(by[0]), .first_t(ft[0]), .first_vld(fv[0]));

  spike_window_emitter #(.LEN(LEN), .GAP(2)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave),
    .spike_out(so[1]), .win_start(ws[1]), .win_last(wl[1]), .t_idx(ti[1]),
    .busy(by[1]), .first_t(ft[1]), .first_vld(fv[1]));

  assign rdy[0] = b0.in_ready;
  assign rdy[1] = b1.in_ready;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  // reference timeline per instance
  int         gap[2] = '{0, 2};
  int         rdy_cyc[2];
  int         st[2];
  bit         have[2];
  logic [0:7] mv[2];
  logic [0:7] q0[$], q1[$];
  bit         en;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lowest(input logic [0:7] v);
    for (int k = 0; k < LEN; k++) if (v[k]) return k;
    return 0;
  endfunction

  task automatic check_cycle(input int d);
    int rel;
    bit in_win, in_gap;
    string p;
    p      = $sformatf("g%0d ", gap[d]);
    rel    = cyc - st[d];
    in_win = have[d] && rel >= 0 && rel < LEN;
    in_gap = have[d] && rel >= LEN && rel < LEN + gap[d];
    chk({p, "in_ready"},  32'(rdy[d]), 32'(cyc >= rdy_cyc[d]));
    chk({p, "busy"},      32'(by[d]),  32'(in_win || in_gap));
    chk({p, "spike_out"}, 32'(so[d]),  32'(in_win ? mv[d][rel] : 1'b0));
    chk({p, "win_start"}, 32'(ws[d]),  32'(in_win && rel == 0));
    chk({p, "win_last"},  32'(wl[d]),  32'(in_win && rel == LEN - 1));
    chk({p, "t_idx"},     32'(ti[d]),  in_win ? 32'(rel) : 32'd0);
    if (in_win) begin
      chk({p, "first_t"},   32'(ft[d]), 32'(lowest(mv[d])));
      chk({p, "first_vld"}, 32'(fv[d]), 32'(mv[d] != '0));
    end
  endtask

  // Drive one instance for this cycle; in_vec is junk when not valid.
  task automatic feed(input int d);
    logic       v;
    logic [0:7] vec;
    v   = en && ((d == 0) ? q0.size() > 0 : q1.size() > 0);
    vec = v ? ((d == 0) ? q0[0] : q1[0]) : 8'($urandom);
    if (d == 0) begin b0.in_valid = v; b0.in_vec = vec; end
    else        begin b1.in_valid = v; b1.in_vec = vec; end
    if (v && cyc >= rdy_cyc[d]) begin
      have[d]    = 1'b1;
      st[d]      = cyc + 1;
      mv[d]      = vec;
      rdy_cyc[d] = cyc + LEN + gap[d];
      if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
  endtask

  // Called at a negedge: check, drive, advance one clock, return at negedge.
  task automatic step();
    check_cycle(0);
    check_cycle(1);
    feed(0);
    feed(1);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic push2(input logic [0:7] v);
    q0.push_back(v);
    q1.push_back(v);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [0:7] rand_vec();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return 8'(1 << $urandom_range(0, 7));
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    b0.in_valid = 1'b0; b0.in_vec = '0;
    b1.in_valid = 1'b0; b1.in_vec = '0;
    en = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rdy_cyc[d] = 0; st[d] = 0; have[d] = 1'b0; mv[d] = '0;
    end

    // reset state
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst in_ready",  32'(rdy[d]), 32'd1);
      chk("rst busy",      32'(by[d]),  32'd0);
      chk("rst spike_out", 32'(so[d]),  32'd0);
      chk("rst t_idx",     32'(ti[d]),  32'd0);
      chk("rst first_vld", 32'(fv[d]),  32'd0);
      chk("rst first_t",   32'(ft[d]),  32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    push2(8'b0100_0000); run(14);            // single spike at t=1
    push2(8'b0110_0011); run(14);            // union vector
    push2(8'b1000_0000); push2(8'b0000_0001);
    run(28);                                 // held valid, back-to-back
    push2(8'b0000_0000); run(14);            // empty window

    // randomized traffic with random valid gating
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) != 0);
      if (q0.size() < 3 && $urandom_range(0, 1) == 1) q0.push_back(rand_vec());
      if (q1.size() < 3 && $urandom_range(0, 1) == 1) q1.push_back(rand_vec());
      step();
    end
    en = 1'b1;
    q0.delete(); q1.delete();
    run(LEN + 4);

    // async reset in the middle of an all-ones window
    push2(8'b1111_1111);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
        if (have[0] && cyc - st[0] == 3) hit = 1'b1;
        else step();
      end
      chk("reach t=3 before reset", 32'(hit), 32'd1);
    end
    check_cycle(0);
    check_cycle(1);
    b0.in_valid = 1'b0; b1.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("midrst spike_out", 32'(so[d]),  32'd0);
      chk("midrst busy",      32'(by[d]),  32'd0);
      chk("midrst in_ready",  32'(rdy[d]), 32'd1);
      chk("midrst win_start", 32'(ws[d]),  32'd0);
      chk("midrst t_idx",     32'(ti[d]),  32'd0);
      chk("midrst first_vld", 32'(fv[d]),  32'd0);
      have[d] = 1'b0;
      rdy_cyc[d] = 0;
    end
    q0.delete(); q1.delete();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    push2(8'b0010_0100); run(14);            // fresh window after reset

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
